// File: rtl/game_update_scheduler.sv
// Per-frame sequencer: agent update slots, then a collision pass.
// Optional per-slot watchdog enabled by defining SCHED_TIMEOUT_EN.
module game_update_scheduler #(
  parameter int N_AGENTS       = 5,
  parameter int FRAME_DIV      = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_stb,
  input  logic                enable,
  input  logic                clear_err,
  input  logic [N_AGENTS-1:0] agent_done,
  input  logic                collide_done,
  output logic [N_AGENTS-1:0] agent_start,
  output logic                collide_start,
  output logic [N_AGENTS-1:0] mem_grant,
  output logic                busy,
  output logic [7:0]          tick_count,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int IW = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [IW-1:0] LAST_SLOT = IW'(N_AGENTS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic [N_AGENTS-1:0] SLOT0 = N_AGENTS'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CSTART,
    CWAIT
  } state_t;

  state_t              state;
  logic [IW-1:0]       slot;
  logic [DW-1:0]       div_cnt;
  logic                err_to;
  logic                expired;
  logic                slot_done;
  logic [N_AGENTS-1:0] next_onehot;
  logic                to_hit;

  assign slot_done   = agent_done[slot];
  assign next_onehot = SLOT0 << (slot + 1'b1);
  assign timeout_err = err_to;

  // A slot that expires without its own done counts as a watchdog hit.
  assign to_hit = expired &&
                  ((state == WAIT && !slot_done) ||
                   (state == CWAIT && !collide_done));

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog;

  assign expired = (wdog == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || state == START || state == CSTART)
      wdog <= '0;
    else if (state == WAIT || state == CWAIT)
      wdog <= wdog + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      slot          <= '0;
      div_cnt       <= '0;
      agent_start   <= '0;
      collide_start <= 1'b0;
      mem_grant     <= '0;
      busy          <= 1'b0;
      tick_count    <= '0;
      overrun       <= 1'b0;
      err_to        <= 1'b0;
    end else begin
      if (frame_stb && busy)
        overrun <= 1'b1;
      else if (clear_err)
        overrun <= 1'b0;

      if (to_hit)
        err_to <= 1'b1;
      else if (clear_err)
        err_to <= 1'b0;

      unique case (state)
        IDLE: begin
          if (frame_stb && enable) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt     <= '0;
              slot        <= '0;
              busy        <= 1'b1;
              agent_start <= SLOT0;
              mem_grant   <= SLOT0;
              state       <= START;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        START: begin
          agent_start <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (slot_done || expired) begin
            if (slot == LAST_SLOT) begin
              mem_grant     <= '0;
              collide_start <= 1'b1;
              state         <= CSTART;
            end else begin
              slot        <= slot + 1'b1;
              agent_start <= next_onehot;
              mem_grant   <= next_onehot;
              state       <= START;
            end
          end
        end
        CSTART: begin
          collide_start <= 1'b0;
          state         <= CWAIT;
        end
        CWAIT: begin
          if (collide_done || expired) begin
            busy       <= 1'b0;
            tick_count <= tick_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_update_scheduler.sv
// Bench for game_update_scheduler: vector table plus start-event scoreboard.
// Agent/collision responders reply after per-slot programmable delays.
module tb_game_update_scheduler;

  localparam int N  = 5;
  localparam int TO = 16;

  typedef struct {
    int           cyc;
    logic [N-1:0] astart;
    logic         cstart;
  } ev_t;

  typedef struct {
    int d0, d1, d2, d3, d4, cd;
    bit same0;
    int len;
  } row_t;

  logic         clk;
  logic         rst, frame_stb, enable, clear_err, collide_done;
  logic [N-1:0] agent_done, agent_start, mem_grant;
  logic         collide_start, busy, overrun, timeout_err;
  logic [7:0]   tick_count;

  logic         b_stb, b_en;
  logic [N-1:0] b_done, b_start, b_grant;
  logic         b_cstart, b_busy, b_ovr, b_to;
  logic [7:0]   b_tick;

  game_update_scheduler #(
    .N_AGENTS(N), .FRAME_DIV(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .frame_stb(frame_stb),
    .enable(enable), .clear_err(clear_err),
    .agent_done(agent_done), .collide_done(collide_done),
    .agent_start(agent_start), .collide_start(collide_start),
    .mem_grant(mem_grant), .busy(busy),
    .tick_count(tick_count), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  game_update_scheduler #(
    .N_AGENTS(N), .FRAME_DIV(3), .TIMEOUT_CYCLES(TO)
  ) dut3 (
    .clk(clk), .rst(rst), .frame_stb(b_stb),
    .enable(b_en), .clear_err(clear_err),
    .agent_done(b_done), .collide_done(collide_done),
    .agent_start(b_start), .collide_start(b_cstart),
    .mem_grant(b_grant), .busy(b_busy),
    .tick_count(b_tick), .overrun(b_ovr),
    .timeout_err(b_to)
  );

  ev_t          sb[$];
  int           cyc, checks, errors;
  int           dly[N];
  bit           same[N];
  int           due[N];
  int           cdly, cdue;
  logic [N-1:0] ghold;
  int           act, act_s;
  row_t         rows[5];

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] a,
                         input logic cs);
    ev_t e;
    e.cyc = c;
    e.astart = a;
    e.cstart = cs;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int t);
    int s;
    logic [N-1:0] v;
    s = t + 1;
    for (int i = 0; i < N; i++) begin
      v = '0;
      v[i] = 1'b1;
      push_ev(s, v, 1'b0);
      s += dly[i] + 1;
    end
    push_ev(s, '0, 1'b1);
  endtask

  task automatic set_dly(input int a, input int b, input int c,
                         input int d, input int e, input int cd);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d; dly[4] = e;
    cdly = cd;
  endtask

  // One clock: sample outputs at the falling edge, then drive responders.
  task automatic step();
    logic [N-1:0] ex;
    ev_t e;
    @(negedge clk);
    cyc++;
    agent_done = '0;
    collide_done = 1'b0;
    if (!rst) begin
      sb.delete();
      ghold = '0;
      for (int i = 0; i < N; i++) due[i] = -1;
      cdue = -1;
      return;
    end
    if (agent_start != '0 || collide_start) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", {agent_start, collide_start}, 0);
      end else begin
        e = sb.pop_front();
        chk("start_cycle", cyc, e.cyc);
        chk("agent_start", agent_start, e.astart);
        chk("collide_start", collide_start, e.cstart);
      end
    end
    chk("start_onehot", $onehot0(agent_start), 1);
    ex = (agent_start != '0) ? agent_start : ghold;
    chk("mem_grant", mem_grant, ex);
    for (int i = 0; i < N; i++) begin
      if (agent_start[i]) begin
        act = i;
        act_s = cyc;
        due[i] = (dly[i] > 0) ? cyc + dly[i] : -1;
        if (same[i]) agent_done[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (due[i] == cyc) begin
        agent_done[i] = 1'b1;
        due[i] = -1;
      end
    end
    if (collide_start) cdue = (cdly > 0) ? cyc + cdly : -1;
    if (cdue == cyc) begin
      collide_done = 1'b1;
      cdue = -1;
    end
    ghold = ex;
    if (ex != '0 && agent_done[act] && cyc > act_s) ghold = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic run_seq(input int len, input int tick_exp,
                         input string name);
    int t;
    t = cyc;
    push_seq(t);
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    wait_idle();
    chk({name, "_len"}, cyc - t, len);
    chk({name, "_tick"}, tick_count, tick_exp);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_agent_start"}, agent_start, 0);
    chk({p, "_collide_start"}, collide_start, 0);
    chk({p, "_mem_grant"}, mem_grant, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_tick"}, tick_count, 0);
    chk({p, "_overrun"}, overrun, 0);
    chk({p, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int t, s;
    clk = 1'b0;
    rst = 1'b0;
    frame_stb = 1'b0;
    enable = 1'b0;
    clear_err = 1'b0;
    agent_done = '0;
    collide_done = 1'b0;
    b_stb = 1'b0;
    b_en = 1'b0;
    b_done = '0;
    cyc = 0;
    checks = 0;
    errors = 0;
    ghold = '0;
    act = 0;
    act_s = 0;
    cdue = -1;
    for (int i = 0; i < N; i++) begin
      same[i] = 1'b0;
      due[i] = -1;
    end
    set_dly(1, 1, 1, 1, 1, 1);

    rows[0] = '{3, 3, 3, 3, 3, 3, 1'b0, 25};
    rows[1] = '{1, 1, 1, 1, 1, 1, 1'b0, 13};
    rows[2] = '{2, 5, 1, 7, 3, 4, 1'b0, 29};
    rows[3] = '{2, 1, 1, 1, 1, 1, 1'b1, 14};
    rows[4] = '{1, 2, 3, 4, 5, 1, 1'b0, 23};

    @(negedge clk);
    step();
    step();
    chk_zero("reset");
    rst = 1'b1;
    enable = 1'b1;
    step();

    for (int r = 0; r < 5; r++) begin
      set_dly(rows[r].d0, rows[r].d1, rows[r].d2,
              rows[r].d3, rows[r].d4, rows[r].cd);
      same[0] = rows[r].same0;
      run_seq(rows[r].len, r + 1, $sformatf("row%0d", r));
      same[0] = 1'b0;
      step();
      step();
    end

    // frame_stb during WAIT(2) is dropped and flagged
    chk("overrun_idle", overrun, 0);
    set_dly(3, 3, 3, 3, 3, 3);
    t = cyc;
    push_seq(t);
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    while (cyc < t + 11) step();
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_idle();
    chk("ovr_len", cyc - t, 25);
    chk("ovr_tick", tick_count, 6);
    repeat (5) step();
    chk("ovr_no_second", busy, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("overrun_clear", overrun, 0);

    // set beats clear; enable drop mid-sequence does not abort
    set_dly(1, 1, 1, 1, 1, 1);
    t = cyc;
    push_seq(t);
    frame_stb = 1'b1;
    step();
    enable = 1'b0;
    clear_err = 1'b1;
    step();
    frame_stb = 1'b0;
    clear_err = 1'b0;
    chk("set_wins", overrun, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clear_again", overrun, 0);
    wait_idle();
    chk("en_drop_len", cyc - t, 13);
    chk("en_drop_tick", tick_count, 7);
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    repeat (3) step();
    chk("en0_ignored", busy, 0);
    enable = 1'b1;

    // reset mid-sequence, then restart from slot 0
    set_dly(3, 3, 3, 3, 3, 3);
    t = cyc;
    push_seq(t);
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    repeat (9) step();
    rst = 1'b0;
    step();
    chk_zero("midrst");
    step();
    rst = 1'b1;
    step();
    run_seq(25, 1, "after_rst");

    // FRAME_DIV=3 instance: disabled pulses do not count
    b_en = 1'b0;
    repeat (2) begin
      b_stb = 1'b1;
      step();
      b_stb = 1'b0;
      step();
    end
    chk("div_en0", b_busy, 0);
    b_en = 1'b1;
    repeat (2) begin
      b_stb = 1'b1;
      step();
      b_stb = 1'b0;
      step();
      chk("div_early", b_busy, 0);
    end
    b_stb = 1'b1;
    step();
    b_stb = 1'b0;
    chk("div_start", b_start, 1);
    chk("div_grant", b_grant, 1);
    chk("div_busy", b_busy, 1);

    // agent 2 never answers
    set_dly(1, 1, -1, 1, 1, 1);
    t = cyc;
    s = t + 5;
    push_ev(t + 1, 5'b00001, 1'b0);
    push_ev(t + 3, 5'b00010, 1'b0);
    push_ev(s, 5'b00100, 1'b0);
`ifdef SCHED_TIMEOUT_EN
    push_ev(s + 17, 5'b01000, 1'b0);
    push_ev(s + 19, 5'b10000, 1'b0);
    push_ev(s + 21, 5'b00000, 1'b1);
`endif
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    while (cyc < s + 16) step();
    chk("to_not_yet", timeout_err, 0);
    step();
    chk("to_set", timeout_err, 1);
    chk("to_next_start", agent_start, 5'b01000);
    wait_idle();
    chk("to_len", cyc - s, 23);
    chk("to_tick", tick_count, 2);
    chk("to_sb_empty", sb.size(), 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("to_clear", timeout_err, 0);
`else
    while (cyc < s + 40) step();
    chk("hang_busy", busy, 1);
    chk("hang_timeout_err", timeout_err, 0);
    chk("hang_grant", mem_grant, 5'b00100);
    chk("hang_no_start", agent_start, 0);
    chk("hang_sb_empty", sb.size(), 0);
`endif

    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
